hs_ad_capture: RTL and testbench
================================

HS_AD_CAPTURE -- requirements
Module: hs_ad_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 256, capture buffer depth in sample pairs (power of two, 16..4096).
REQ-002 SHALL have parameter PRE_TRIG, default 64, samples kept before the trigger (1 <= PRE_TRIG < DEPTH).
REQ-003 SHALL have port sys_clk  input  1  single clock, all logic on its rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports ad0_data / ad1_data  input  10 each  ADC channel samples.
REQ-006 SHALL have ports ad0_otr / ad1_otr  input  1 each  ADC out-of-range flags.
REQ-007 SHALL have port arm  input  1  single-cycle pulse that starts a capture.
REQ-008 SHALL have port trig_level  input  10  channel-0 rising-edge trigger threshold.
REQ-009 SHALL have port rd_en  input  1  readout request, one word per asserted cycle.
REQ-010 SHALL have port rd_data  output  20  read word {ch1, ch0}.
REQ-011 SHALL have port rd_valid  output  1  rd_data valid strobe.
REQ-012 SHALL have ports busy / done  output  1 each  capture in progress / buffer ready for readout.
REQ-013 SHALL have port otr_flag  output  1  sticky out-of-range indication.

Function
REQ-014 SHALL register ad0/ad1 data and otr on every sys_clk edge (input stage, 1 cycle); all later logic uses registered values.
REQ-015 SHALL implement FSM states IDLE, PRE, WAIT_TRIG, POST, DONE.
REQ-016 IDLE: arm=1 -> PRE; write address cleared to 0; otr_flag cleared.
REQ-017 PRE: write one {ch1,ch0} word per cycle, address incrementing mod DEPTH; after PRE_TRIG writes -> WAIT_TRIG.
REQ-018 WAIT_TRIG: keep writing, wrapping mod DEPTH; trigger when previous ch0 < trig_level and current ch0 >= trig_level (unsigned); trigger sample is written and its address latched as trig_addr -> POST.
REQ-019 Crossings during PRE SHALL be ignored; the first qualifying crossing in WAIT_TRIG wins.
REQ-020 POST: write exactly DEPTH-PRE_TRIG-1 further samples, then -> DONE with no more writes.
REQ-021 DONE: done=1; readout pointer starts at (trig_addr - PRE_TRIG) mod DEPTH; each rd_en cycle reads one word and advances the pointer mod DEPTH.
REQ-022 rd_valid SHALL assert exactly one cycle after each accepted rd_en, with rd_data holding that word; rd_data holds its value otherwise.
REQ-023 After DEPTH accepted reads -> IDLE; done clears in the same cycle as the final rd_valid.
REQ-024 busy=1 in PRE, WAIT_TRIG and POST; 0 otherwise.
REQ-025 arm outside IDLE SHALL be ignored; rd_en outside DONE SHALL be ignored (no rd_valid).
REQ-026 Readout word index PRE_TRIG SHALL be the trigger sample; index 0 is PRE_TRIG samples earlier.

Reset
REQ-027 On sys_rst_n=0 at a clock edge: state IDLE; busy, done, rd_valid, otr_flag = 0; rd_data = 0; pointers = 0; applies mid-capture and mid-readout.
REQ-028 Buffer contents SHALL NOT be reset; they are undefined after reset.

Configuration
REQ-029 Macro HS_AD_OTR_EN defined: otr_flag sets when either registered otr is 1 during PRE/WAIT_TRIG/POST and stays set until the next accepted arm or reset.
REQ-030 HS_AD_OTR_EN undefined: otr_flag tied to 0; no OTR logic synthesised; all other behaviour identical.

Structure
REQ-031 Package hs_ad_pkg SHALL hold the FSM state typedef, AD_W=10 and WORD_W=20 constants.
REQ-032 Sub-module hs_ad_ram (simple dual-port, one write port, registered read port, DEPTH x WORD_W) SHALL hold the buffer.

Verification
REQ-033 ad0 ramps 0,1,2..1023 wrapping, ad1=ad0^10'h3FF, trig_level=512, arm, then DEPTH reads -> word 0 ch0=448, word 64 ch0=512, word 255 ch0=703, ch1 matches.
REQ-034 Crossing of 512 during PRE (sample 10), next crossing 300 cycles later -> trigger at the later crossing; word 64 = that sample.
REQ-035 arm pulsed during WAIT_TRIG and during DONE -> no state change, captured data unchanged.
REQ-036 sys_rst_n=0 for 1 cycle in POST -> next cycle busy=0, done=0, state IDLE; new arm captures normally.
REQ-037 rd_en toggling 1,0,1,1 in DONE -> rd_valid 0,1,0,1,1 with consecutive words; rd_en in IDLE -> no rd_valid.
REQ-038 With HS_AD_OTR_EN, ad1_otr=1 for one cycle in WAIT_TRIG -> otr_flag=1 until next arm; without macro -> otr_flag stays 0.

Source files
------------

// File: rtl/hs_ad_pkg.sv
// Shared widths, FSM state type and word packing for the dual-channel ADC capture block.
package hs_ad_pkg;

  localparam int AD_W   = 10;
  localparam int WORD_W = 20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } state_e;

  function automatic logic [WORD_W-1:0] pack_word(input logic [AD_W-1:0] ch1,
                                                  input logic [AD_W-1:0] ch0);
    return {ch1, ch0};
  endfunction

endpackage

// File: rtl/hs_ad_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port.
// The read register clears on reset; the storage array itself is never reset.
module hs_ad_ram
  import hs_ad_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WORD_W-1:0]        rd_data
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Output holds its last word between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/hs_ad_capture.sv
// Dual-channel ADC snapshot capture: pre/post-trigger ring buffer with word-serial readout.
// Define HS_AD_OTR_EN to build the sticky out-of-range flag; otherwise otr_flag is tied low.
module hs_ad_capture
  import hs_ad_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int PRE_TRIG = 64
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [AD_W-1:0]   ad0_data,
  input  logic [AD_W-1:0]   ad1_data,
  input  logic              ad0_otr,
  input  logic              ad1_otr,
  input  logic              arm,
  input  logic [AD_W-1:0]   trig_level,
  input  logic              rd_en,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              otr_flag
);

  localparam int              AW        = $clog2(DEPTH);
  localparam int              POST_N    = DEPTH - PRE_TRIG - 1;
  localparam logic [AW-1:0]   PRE_OFS   = AW'(PRE_TRIG);
  localparam logic [AW-1:0]   PRE_LAST  = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0]   POST_LAST = AW'(POST_N - 1);
  localparam logic [AW-1:0]   RD_LAST   = AW'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [AD_W-1:0]   ch0_q, ch1_q, ch0_prev_q;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     trig_addr_q, trig_addr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              rd_valid_q;
  logic              wr_en, rd_acc, trig_hit;
  logic [WORD_W-1:0] wr_word;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ch0_q      <= '0;
      ch1_q      <= '0;
      ch0_prev_q <= '0;
    end else begin
      ch0_q      <= ad0_data;
      ch1_q      <= ad1_data;
      ch0_prev_q <= ch0_q;
    end
  end

  assign trig_hit = (ch0_prev_q < trig_level) && (ch0_q >= trig_level);
  assign wr_word  = pack_word(ch1_q, ch0_q);

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    cnt_d       = cnt_q;
    trig_addr_d = trig_addr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_en       = 1'b0;
    rd_acc      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d   = S_PRE;
          wr_addr_d = '0;
          cnt_d     = '0;
        end
      end
      S_PRE: begin
        wr_en     = 1'b1;
        wr_addr_d = wr_addr_q + 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == PRE_LAST) begin
          state_d = S_WAIT_TRIG;
          cnt_d   = '0;
        end
      end
      S_WAIT_TRIG: begin
        wr_en     = 1'b1;
        wr_addr_d = wr_addr_q + 1'b1;
        if (trig_hit) begin
          trig_addr_d = wr_addr_q;
          cnt_d       = '0;
          // With PRE_TRIG = DEPTH-1 the trigger sample fills the buffer.
          if (POST_N == 0) begin
            state_d  = S_DONE;
            rd_ptr_d = wr_addr_q - PRE_OFS;
          end else begin
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        wr_en     = 1'b1;
        wr_addr_d = wr_addr_q + 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == POST_LAST) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          rd_ptr_d = trig_addr_q - PRE_OFS;
        end
      end
      S_DONE: begin
        if (rd_en) begin
          rd_acc   = 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == RD_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      wr_addr_q   <= '0;
      cnt_q       <= '0;
      trig_addr_q <= '0;
      rd_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      cnt_q       <= cnt_d;
      trig_addr_q <= trig_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_valid_q  <= rd_acc;
    end
  end

  assign busy     = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
  assign done     = (state_q == S_DONE);
  assign rd_valid = rd_valid_q;

`ifdef HS_AD_OTR_EN
  logic otr0_q, otr1_q, otr_flag_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      otr0_q     <= 1'b0;
      otr1_q     <= 1'b0;
      otr_flag_q <= 1'b0;
    end else begin
      otr0_q <= ad0_otr;
      otr1_q <= ad1_otr;
      if ((state_q == S_IDLE) && arm) begin
        otr_flag_q <= 1'b0;
      end else if (busy && (otr0_q || otr1_q)) begin
        otr_flag_q <= 1'b1;
      end
    end
  end

  assign otr_flag = otr_flag_q;
`else
  logic unused_otr;
  assign unused_otr = ad0_otr | ad1_otr;
  assign otr_flag   = 1'b0;
`endif

  hs_ad_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .wr_en  (wr_en),
    .wr_addr(wr_addr_q),
    .wr_data(wr_word),
    .rd_en  (rd_acc),
    .rd_addr(rd_ptr_q),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_hs_ad_capture.sv
// Randomised bench for hs_ad_capture: expected snapshots are taken from the recorded sample stream.
module tb_hs_ad_capture;

  localparam int DEPTH    = 256;
  localparam int PRE_TRIG = 64;
`ifdef HS_AD_OTR_EN
  localparam bit OTR_ON = 1'b1;
`else
  localparam bit OTR_ON = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [9:0]  ad0_data, ad1_data;
  logic        ad0_otr, ad1_otr;
  logic        arm;
  logic [9:0]  trig_level;
  logic        rd_en;
  logic [19:0] rd_data;
  logic        rd_valid, busy, done, otr_flag;

  hs_ad_capture #(
    .DEPTH   (DEPTH),
    .PRE_TRIG(PRE_TRIG)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ad0_data  (ad0_data),
    .ad1_data  (ad1_data),
    .ad0_otr   (ad0_otr),
    .ad1_otr   (ad1_otr),
    .arm       (arm),
    .trig_level(trig_level),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .done      (done),
    .otr_flag  (otr_flag)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          cap_a, cap_j;
  bit          otr_exp = 1'b0;
  logic [9:0]  h0[$];
  logic [9:0]  h1[$];
  logic [19:0] exp_w[DEPTH];
  logic [19:0] got_w[DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: record the sample presented at this edge, then settle outputs.
  task automatic step();
    @(posedge sys_clk);
    h0.push_back(ad0_data);
    h1.push_back(ad1_data);
    cyc++;
    #1;
  endtask

  task automatic drive_sample(input int mode, input int k, input logic [9:0] lvl);
    logic [9:0] v;
    if (mode == 0 || mode == 3) begin
      v = 10'(k);
      ad0_data = v;
      ad1_data = v ^ 10'h3FF;
    end else begin
      if (mode == 1) begin
        if ((k >= 10 && k < 20) || k >= 310) v = 10'($urandom_range(int'(lvl), 1023));
        else                                 v = 10'($urandom_range(0, int'(lvl) - 1));
      end else begin
        if (k < 200) v = 10'($urandom_range(0, int'(lvl) - 1));
        else         v = 10'($urandom);
      end
      ad0_data = v;
      ad1_data = 10'($urandom);
    end
  endtask

  task automatic run_capture(input int mode, input logic [9:0] lvl, output bit ok);
    int  done_idx, j, idx;
    bit  seen;
    ok         = 1'b0;
    seen       = 1'b0;
    done_idx   = 0;
    trig_level = lvl;
    cap_a      = cyc;
    drive_sample(mode, 0, lvl);
    arm = 1'b1;
    step();
    arm = 1'b0;
    otr_exp = 1'b0;
    check("arm_busy", 32'(busy), 32'd1);
    check("arm_otr_clear", 32'(otr_flag), 32'(otr_exp));
    for (int k = 1; k < 8000 && !seen; k++) begin
      drive_sample(mode, k, lvl);
      if (mode == 2 && k == 100) arm = 1'b1;
      if (mode == 2 && k == 120) ad1_otr = 1'b1;
      step();
      arm     = 1'b0;
      ad1_otr = 1'b0;
      if (mode == 2 && k == 100) check("arm_in_wait_busy", 32'(busy), 32'd1);
      if (mode == 2 && k == 122) begin
        otr_exp = OTR_ON;
        check("otr_set", 32'(otr_flag), 32'(otr_exp));
      end
      if (mode == 3 && k == 600) begin
        check("post_busy", 32'(busy), 32'd1);
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        check("midrst_otr", 32'(otr_flag), 32'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("midrst_idle_rd", 32'(rd_valid), 32'd0);
        $display("capture mode=%0d arm_idx=%0d reset at k=600", mode, cap_a);
        return;
      end
      if (done) begin
        seen     = 1'b1;
        done_idx = cyc - 1;
      end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    j = -1;
    for (int i = cap_a + PRE_TRIG; i < h0.size() && j < 0; i++) begin
      if (h0[i-1] < lvl && h0[i] >= lvl) j = i;
    end
    if (j < 0) begin
      check("model_trigger_found", 32'd0, 32'd1);
      return;
    end
    cap_j = j;
    check("done_latency", 32'(done_idx), 32'(j + DEPTH - PRE_TRIG));
    check("done_busy", 32'(busy), 32'd0);
    check("done_otr", 32'(otr_flag), 32'(otr_exp));
    for (int n = 0; n < DEPTH; n++) begin
      idx = j - PRE_TRIG + n;
      exp_w[n] = (idx < h0.size()) ? {h1[idx], h0[idx]} : 20'hFFFFF;
    end
    if (mode == 2) begin
      arm = 1'b1;
      step();
      arm = 1'b0;
      check("arm_in_done_done", 32'(done), 32'd1);
      check("arm_in_done_busy", 32'(busy), 32'd0);
      check("arm_in_done_otr", 32'(otr_flag), 32'(otr_exp));
    end
    $display("capture mode=%0d arm_idx=%0d trig_idx=%0d done_idx=%0d", mode, cap_a, j, done_idx);
    ok = 1'b1;
  endtask

  task automatic readout();
    bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit en;
    int n_got = 0;
    check("pre_read_rd_valid", 32'(rd_valid), 32'd0);
    for (int c = 0; n_got < DEPTH && c < 4 * DEPTH + 16; c++) begin
      en = (c < 4) ? pat[c] : 1'($urandom_range(0, 1));
      rd_en = en;
      step();
      if (en) begin
        check("rd_valid_hi", 32'(rd_valid), 32'd1);
        check("rd_word", 32'(rd_data), 32'(exp_w[n_got]));
        got_w[n_got] = rd_data;
        n_got++;
      end else begin
        check("rd_valid_lo", 32'(rd_valid), 32'd0);
        if (n_got > 0) check("rd_hold", 32'(rd_data), 32'(exp_w[n_got-1]));
      end
      check("rd_done", 32'(done), 32'(n_got < DEPTH));
    end
    rd_en = 1'b0;
    if (n_got < DEPTH) check("rd_timeout", 32'(n_got), 32'(DEPTH));
    step();
    check("post_read_valid", 32'(rd_valid), 32'd0);
    check("post_read_busy", 32'(busy), 32'd0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("idle_rd_ignored", 32'(rd_valid), 32'd0);
    $display("readout words=%0d", n_got);
  endtask

  task automatic check_ramp();
    check("ramp_w0_ch0", 32'(got_w[0][9:0]), 32'd448);
    check("ramp_w64_ch0", 32'(got_w[PRE_TRIG][9:0]), 32'd512);
    check("ramp_w255_ch0", 32'(got_w[DEPTH-1][9:0]), 32'd703);
    check("ramp_w0_ch1", 32'(got_w[0][19:10]), 32'(10'd448 ^ 10'h3FF));
    check("ramp_w255_ch1", 32'(got_w[DEPTH-1][19:10]), 32'(10'd703 ^ 10'h3FF));
  endtask

  initial begin
    bit         ok;
    logic [9:0] lvl2;
    sys_rst_n  = 1'b0;
    arm        = 1'b0;
    rd_en      = 1'b0;
    ad0_data   = '0;
    ad1_data   = '0;
    ad0_otr    = 1'b0;
    ad1_otr    = 1'b0;
    trig_level = 10'd512;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_otr", 32'(otr_flag), 32'd0);
    sys_rst_n = 1'b1;
    step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("idle_rd_en", 32'(rd_valid), 32'd0);
    step();

    run_capture(0, 10'd512, ok);
    if (ok) begin
      readout();
      check_ramp();
    end

    run_capture(1, 10'd512, ok);
    if (ok) begin
      readout();
      check("late_cross_idx", 32'(cap_j - cap_a), 32'd310);
      check("late_cross_w64", 32'(got_w[PRE_TRIG]), 32'({h1[cap_a+310], h0[cap_a+310]}));
    end

    lvl2 = 10'($urandom_range(200, 900));
    run_capture(2, lvl2, ok);
    if (ok) readout();

    run_capture(3, 10'd512, ok);

    run_capture(0, 10'd512, ok);
    if (ok) begin
      readout();
      check_ramp();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
